// File: rtl/io_pkg.sv
// io_pkg: shared widths, the write-queue entry type and the FIFO pointer-width helper
// for the IO port controller.
package io_pkg;

    localparam int IO_ID_WID   = 8;
    localparam int IO_DATA_WID = 8;

    // One queued output write: destination port and byte.
    typedef struct packed {
        logic [IO_ID_WID-1:0]   id;
        logic [IO_DATA_WID-1:0] data;
    } io_entry_t;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    function automatic int io_ptr_wid(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_sync_fifo.sv
// io_sync_fifo: synchronous FIFO with a push/full write side and a valid/ready read side.
// Handshake: the head entry transfers on a rising clk edge where o_valid && i_ready are
// both 1; o_data holds steady while o_valid && !i_ready. A push is taken when
// i_push && (!o_full || pop), so a full FIFO can accept a push on the cycle it pops.
module io_sync_fifo
    import io_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data
);

    localparam int PTR_W = io_ptr_wid(DEPTH);
    localparam int IDX_W = PTR_W - 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W-1] != r_rd_ptr[PTR_W-1]) &&
                     (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
    assign w_pop   = !w_empty && i_ready;
    assign w_push  = i_push && (!w_full || w_pop);

    // Storage and pointers; pointers wrap naturally through the extra MSB
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr[IDX_W-1:0]] <= i_data;
                r_wr_ptr                   <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    assign o_full  = w_full;
    assign o_valid = !w_empty;
    assign o_data  = w_empty ? '0 : r_mem[r_rd_ptr[IDX_W-1:0]];

endmodule

// File: rtl/io_port_ctrl.sv
// io_port_ctrl: processor-side IO port controller. Latches per-port output registers,
// queues accepted writes for an external peripheral, and returns synchronised input bytes.
// Optional macro IO_PORT_ERR_EN adds sticky range-error flags and a stalled-write counter.
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 4,
    parameter int NUM_IN_PORTS  = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [IO_ID_WID-1:0]         IO_port_ID,
    input  logic [IO_DATA_WID-1:0]       IO_write_data,
    input  logic                         IO_write_strobe,
    input  logic                         IO_read_strobe,
    input  logic [NUM_IN_PORTS*8-1:0]    in_port_data,
    output logic [IO_DATA_WID-1:0]       IO_read_data,
    output logic [NUM_OUT_PORTS*8-1:0]   out_port_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IO_ID_WID-1:0]         out_id,
    output logic [IO_DATA_WID-1:0]       out_data,
    output logic                         io_stall,
    output logic                         read_ack
`ifdef IO_PORT_ERR_EN
    ,
    output logic [1:0]                   err_flags,
    output logic [7:0]                   ovf_cnt
`endif
);

    localparam logic [IO_ID_WID-1:0] OUT_LIM = IO_ID_WID'(NUM_OUT_PORTS);
    localparam logic [IO_ID_WID-1:0] IN_LIM  = IO_ID_WID'(NUM_IN_PORTS);

    logic [NUM_IN_PORTS*8-1:0]  r_sync1;
    logic [NUM_IN_PORTS*8-1:0]  r_sync2;
    logic [NUM_OUT_PORTS*8-1:0] r_out_port;
    logic                       r_read_ack;
    logic                       w_wr_in_range;
    logic                       w_rd_in_range;
    logic                       w_wr_valid;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_push;
    logic                       w_stall;
    logic [IO_DATA_WID-1:0]     w_read_data;
    io_entry_t                  w_push_entry;
    io_entry_t                  w_head;
    logic [$bits(io_entry_t)-1:0] w_head_bits;

    assign w_wr_in_range = (IO_port_ID < OUT_LIM);
    assign w_rd_in_range = (IO_port_ID < IN_LIM);
    assign w_wr_valid    = IO_write_strobe && w_wr_in_range;
    assign w_pop         = out_valid && out_ready;
    assign w_push        = w_wr_valid && (!w_full || w_pop);
    assign w_stall       = w_wr_valid && w_full && !out_ready;
    assign w_push_entry  = '{id: IO_port_ID, data: IO_write_data};

    io_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(io_entry_t))
    ) u_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .o_full  (w_full),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_data  (w_head_bits)
    );

    assign w_head = io_entry_t'(w_head_bits);

    // Two-flop synchroniser on every external input byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port_data;
            r_sync2 <= r_sync1;
        end
    end

    // Input-port select; out-of-range IDs read as zero
    always_comb begin
        w_read_data = '0;
        for (int i = 0; i < NUM_IN_PORTS; i++) begin
            if (IO_port_ID == IO_ID_WID'(i)) begin
                w_read_data = r_sync2[i*8 +: 8];
            end
        end
    end

    // Output registers track the last accepted write per port; read_ack follows a valid read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_port <= '0;
            r_read_ack <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (w_push && (IO_port_ID == IO_ID_WID'(i))) begin
                    r_out_port[i*8 +: 8] <= IO_write_data;
                end
            end
            r_read_ack <= IO_read_strobe && w_rd_in_range;
        end
    end

`ifdef IO_PORT_ERR_EN
    logic [1:0] r_err_flags;
    logic [7:0] r_ovf_cnt;

    // Sticky range-error flags and a saturating count of stalled-write cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err_flags <= '0;
            r_ovf_cnt   <= '0;
        end else begin
            if (IO_write_strobe && !w_wr_in_range) begin
                r_err_flags[0] <= 1'b1;
            end
            if (IO_read_strobe && !w_rd_in_range) begin
                r_err_flags[1] <= 1'b1;
            end
            if (w_stall && (r_ovf_cnt != 8'hFF)) begin
                r_ovf_cnt <= r_ovf_cnt + 8'd1;
            end
        end
    end

    assign err_flags = r_err_flags;
    assign ovf_cnt   = r_ovf_cnt;
`endif

    assign IO_read_data  = w_read_data;
    assign out_port_data = r_out_port;
    assign out_id        = w_head.id;
    assign out_data      = w_head.data;
    assign io_stall      = w_stall;
    assign read_ack      = r_read_ack;

endmodule

// File: tb/tb_io_port_ctrl.sv
// tb_io_port_ctrl: directed and randomized checks of io_port_ctrl against a queue-based
// reference model of the write path and a pin-history model of the input path.
module tb_io_port_ctrl;

    localparam int NO    = 4;
    localparam int NI    = 4;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [7:0]  IO_port_ID;
    logic [7:0]  IO_write_data;
    logic        IO_write_strobe;
    logic        IO_read_strobe;
    logic [31:0] in_port_data;
    logic [7:0]  IO_read_data;
    logic [31:0] out_port_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_id;
    logic [7:0]  out_data;
    logic        io_stall;
    logic        read_ack;
`ifdef IO_PORT_ERR_EN
    logic [1:0]  err_flags;
    logic [7:0]  ovf_cnt;
`endif

    io_port_ctrl #(
        .NUM_OUT_PORTS (NO),
        .NUM_IN_PORTS  (NI),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .IO_port_ID      (IO_port_ID),
        .IO_write_data   (IO_write_data),
        .IO_write_strobe (IO_write_strobe),
        .IO_read_strobe  (IO_read_strobe),
        .in_port_data    (in_port_data),
        .IO_read_data    (IO_read_data),
        .out_port_data   (out_port_data),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_id          (out_id),
        .out_data        (out_data),
        .io_stall        (io_stall),
        .read_ack        (read_ack)
`ifdef IO_PORT_ERR_EN
        ,
        .err_flags       (err_flags),
        .ovf_cnt         (ovf_cnt)
`endif
    );

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];       // {id, data}, head at index 0
    logic [7:0]  m_port [NO];
    logic [31:0] m_pin_1;        // pins seen at the most recent edge
    logic [31:0] m_pin_2;        // pins seen one edge before that (visible now)
    logic        m_ack;
    logic [1:0]  m_err;
    int          m_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        for (int i = 0; i < NO; i++) m_port[i] = 8'h00;
        m_pin_1 = '0;
        m_pin_2 = '0;
        m_ack   = 1'b0;
        m_err   = 2'b00;
        m_ovf   = 0;
    endtask

    function automatic logic [31:0] model_ports();
        return {m_port[3], m_port[2], m_port[1], m_port[0]};
    endfunction

    // ---------------- driver: one clock cycle with full checking ----------------
    task automatic cycle(input logic ws, input logic [7:0] id, input logic [7:0] wd,
                         input logic rs, input logic rdy, input logic [31:0] pins,
                         output logic stalled);
        logic       wr_ok;
        logic       full;
        logic       pop;
        logic       exp_stall;
        logic [7:0] exp_rd;
        IO_write_strobe = ws;
        IO_port_ID      = id;
        IO_write_data   = wd;
        IO_read_strobe  = rs;
        out_ready       = rdy;
        in_port_data    = pins;
        #2;
        wr_ok     = ws && (int'(id) < NO);
        full      = (exp_q.size() == DEPTH);
        pop       = (exp_q.size() > 0) && rdy;
        exp_stall = wr_ok && full && !rdy;
        exp_rd    = (int'(id) < NI) ? m_pin_2[int'(id)*8 +: 8] : 8'h00;
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            chk("out_id",   32'(out_id),   32'(exp_q[0][15:8]));
            chk("out_data", 32'(out_data), 32'(exp_q[0][7:0]));
        end
        chk("io_stall",      32'(io_stall),     32'(exp_stall));
        chk("IO_read_data",  32'(IO_read_data), 32'(exp_rd));
        chk("read_ack",      32'(read_ack),     32'(m_ack));
        chk("out_port_data", out_port_data,     model_ports());
`ifdef IO_PORT_ERR_EN
        chk("err_flags", 32'(err_flags), 32'(m_err));
        chk("ovf_cnt",   32'(ovf_cnt),   32'(m_ovf));
`endif
        @(posedge clk);
        if (pop) void'(exp_q.pop_front());
        if (wr_ok && (!full || pop)) begin
            exp_q.push_back({id, wd});
            m_port[int'(id)] = wd;
        end
        m_ack   = rs && (int'(id) < NI);
        m_pin_2 = m_pin_1;
        m_pin_1 = pins;
        if (ws && (int'(id) >= NO)) m_err[0] = 1'b1;
        if (rs && (int'(id) >= NI)) m_err[1] = 1'b1;
        if (exp_stall && (m_ovf < 255)) m_ovf++;
        stalled = exp_stall;
        #1;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic        st;
        logic        ws;
        logic [7:0]  id;
        logic [7:0]  wd;
        logic        rdy;
        logic [31:0] pins;

        reset           = 1'b0;
        IO_port_ID      = '0;
        IO_write_data   = '0;
        IO_write_strobe = 1'b0;
        IO_read_strobe  = 1'b0;
        in_port_data    = '0;
        out_ready       = 1'b0;
        model_reset();
        pins = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid",     32'(out_valid),    32'd0);
        chk("rst_out_id",        32'(out_id),       32'd0);
        chk("rst_out_data",      32'(out_data),     32'd0);
        chk("rst_io_stall",      32'(io_stall),     32'd0);
        chk("rst_read_ack",      32'(read_ack),     32'd0);
        chk("rst_out_port_data", out_port_data,     32'd0);
        chk("rst_IO_read_data",  32'(IO_read_data), 32'd0);
        #4 reset = 1'b1;
        @(posedge clk);
        #1;

        // Single write, peripheral ready
        cycle(1'b1, 8'd2, 8'hA5, 1'b0, 1'b1, pins, st);
        chk("tp1_port2", 32'(out_port_data[23:16]), 32'hA5);
        chk("tp1_valid", 32'(out_valid), 32'd1);
        cycle(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, pins, st);
        chk("tp1_empty", 32'(out_valid), 32'd0);

        // Fill while blocked, fifth write stalls, then drains in order
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i), 8'(8'h10 + i), 1'b0, 1'b0, pins, st);
        cycle(1'b1, 8'd0, 8'h50, 1'b0, 1'b0, pins, st);
        chk("tp2_stall_port0", 32'(out_port_data[7:0]), 32'h10);
        cycle(1'b1, 8'd0, 8'h50, 1'b0, 1'b0, pins, st);
        cycle(1'b1, 8'd0, 8'h50, 1'b0, 1'b1, pins, st);
        chk("tp2_accept_port0", 32'(out_port_data[7:0]), 32'h50);
        repeat (5) cycle(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, pins, st);

        // Full FIFO with simultaneous pop and push
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(i), 8'(8'h20 + i), 1'b0, 1'b0, pins, st);
        cycle(1'b1, 8'd1, 8'h3C, 1'b0, 1'b1, pins, st);
        chk("tp3_head", 32'(out_data), 32'h21);
        repeat (5) cycle(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, pins, st);

        // Input synchroniser latency and read_ack
        pins = 32'h7E00_0000;
        cycle(1'b0, 8'd3, 8'h00, 1'b0, 1'b0, pins, st);
        chk("tp4_read_early", 32'(IO_read_data), 32'h00);
        cycle(1'b0, 8'd3, 8'h00, 1'b0, 1'b0, pins, st);
        chk("tp4_read_sync", 32'(IO_read_data), 32'h7E);
        cycle(1'b0, 8'd3, 8'h00, 1'b1, 1'b0, pins, st);
        chk("tp4_ack", 32'(read_ack), 32'd1);
        cycle(1'b0, 8'd9, 8'h00, 1'b1, 1'b0, pins, st);
        chk("tp4_oor_ack", 32'(read_ack), 32'd0);
        chk("tp4_oor_data", 32'(IO_read_data), 32'h00);

        // Out-of-range write is ignored
        cycle(1'b1, 8'd8, 8'hEE, 1'b0, 1'b0, pins, st);
        chk("tp5_no_push", 32'(out_valid), 32'd0);
        cycle(1'b0, 8'd0, 8'h00, 1'b0, 1'b0, pins, st);
`ifdef IO_PORT_ERR_EN
        chk("tp5_err0", 32'(err_flags[0]), 32'd1);
`endif

        // Asynchronous reset with entries queued
        pins = '0;
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i), 8'(8'h60 + i), 1'b0, 1'b0, pins, st);
        cycle(1'b0, 8'd0, 8'h00, 1'b0, 1'b0, pins, st);
        chk("tp6_pre_valid", 32'(out_valid), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("tp6_valid",  32'(out_valid),  32'd0);
        chk("tp6_id",     32'(out_id),     32'd0);
        chk("tp6_data",   32'(out_data),   32'd0);
        chk("tp6_ports",  out_port_data,   32'd0);
        chk("tp6_stall",  32'(io_stall),   32'd0);
        model_reset();
        @(posedge clk);
        #4 reset = 1'b1;
        @(posedge clk);
        #1;
        cycle(1'b0, 8'd0, 8'h00, 1'b0, 1'b1, pins, st);
        chk("tp6_after_empty", 32'(out_valid), 32'd0);

        // Randomized traffic; a stalled write is re-presented until accepted
        st = 1'b0;
        ws = 1'b0;
        id = '0;
        wd = '0;
        for (int n = 0; n < 600; n++) begin
            if (!st) begin
                ws = 1'($urandom_range(0, 1));
                id = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(4, 255))
                                                  : 8'($urandom_range(0, 3));
                wd = 8'($urandom);
            end
            rdy = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0) pins = $urandom;
            cycle(ws, id, wd, 1'($urandom_range(0, 1)), rdy, pins, st);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
